microwave_cook_ctrl: RTL and testbench



---
 rtl/microwave_cook_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_microwave_cook_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_cook_ctrl.sv
// microwave_cook_ctrl: sequencing controller for the microwave cook cycle.
// Owns the BCD MM:SS cook-time register, takes time entry and start/stop
// commands, counts down on a 1 Hz tick, gates the magnetron, enforces the
// door interlock and drives a timed end-of-cook beep.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   tick_1hz                        one-cycle pulse once per second
//   btn_add_min, btn_add_10s        one-cycle pulses: add 1:00 / 0:10
//   btn_start                       one-cycle pulse: start / pause / resume
//   btn_stop                        one-cycle pulse: pause when cooking, else clear
//   door_open                       level, 1 = door open
//   min_tens..sec_ones              BCD remaining time (registered)
//   heat_on                         magnetron enable (registered)
//   done_beep                       buzzer enable (registered)
//   state                           IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4
module microwave_cook_ctrl #(
  parameter int unsigned BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_add_min,
  input  logic       btn_add_10s,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heat_on,
  output logic       done_beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [15:0] TimeMax = 16'h9959;

  state_e      state_q, state_d;
  logic [15:0] time_q, time_d;      // {min_tens, min_ones, sec_tens, sec_ones}
  logic [3:0]  beep_cnt_q, beep_cnt_d;
  logic        heat_q, heat_d;
  logic        beep_q, beep_d;

  logic        add_any;
  logic        time_nz;
  logic [15:0] time_add_s;
  logic [15:0] time_add;

  // Add one minute; anything past 99 minutes saturates the whole time to 99:59.
  function automatic logic [15:0] inc_min(input logic [15:0] t);
    if (t[15:12] == 4'd9 && t[11:8] == 4'd9) return TimeMax;
    if (t[11:8] == 4'd9) return {t[15:12] + 4'd1, 4'd0, t[7:0]};
    return {t[15:12], t[11:8] + 4'd1, t[7:0]};
  endfunction

  // Add ten seconds with a carry into the minutes when sec_tens wraps past 5.
  function automatic logic [15:0] inc_10s(input logic [15:0] t);
    if (t[7:4] >= 4'd5) return inc_min({t[15:8], 4'd0, t[3:0]});
    return {t[15:8], t[7:4] + 4'd1, t[3:0]};
  endfunction

  // Subtract one second with BCD borrow. Never called on 00:00.
  function automatic logic [15:0] dec_sec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  always_comb begin
    add_any    = btn_add_min | btn_add_10s;
    time_nz    = (time_q != 16'h0000);
    time_add_s = btn_add_10s ? inc_10s(time_q) : time_q;
    time_add   = btn_add_min ? inc_min(time_add_s) : time_add_s;
  end

  // Each state only reacts to events that are meaningful in it; among those,
  // the highest-priority one wins and everything below it is dropped.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    beep_cnt_d = beep_cnt_q;

    case (state_q)
      StIdle: begin
        if (add_any) begin
          time_d  = time_add;
          state_d = StSet;
        end
      end

      StSet: begin
        if (btn_stop) begin
          time_d  = 16'h0000;
          state_d = StIdle;
        end else if (btn_start && !door_open && time_nz) begin
          state_d = StCook;
        end else if (add_any) begin
          time_d = time_add;
        end
      end

      StCook: begin
        if (door_open || btn_stop || btn_start) begin
          state_d = StPause;
        end else if (btn_add_min) begin
          time_d = inc_min(time_q);
        end else if (tick_1hz) begin
          time_d = dec_sec(time_q);
          if (time_q == 16'h0001) begin
            state_d    = StDone;
            beep_cnt_d = 4'd0;
          end
        end
      end

      StPause: begin
        if (btn_stop) begin
          time_d  = 16'h0000;
          state_d = StIdle;
        end else if (btn_start && !door_open && time_nz) begin
          state_d = StCook;
        end else if (add_any) begin
          time_d = time_add;
        end
      end

      StDone: begin
        if (door_open || btn_stop || btn_start || add_any) begin
          state_d    = StIdle;
          beep_cnt_d = 4'd0;
        end else if (tick_1hz) begin
          if (beep_cnt_q == 4'(BEEP_SECS - 1)) begin
            state_d    = StIdle;
            beep_cnt_d = 4'd0;
          end else begin
            beep_cnt_d = beep_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d    = StIdle;
        time_d     = 16'h0000;
        beep_cnt_d = 4'd0;
      end
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    heat_d = (state_d == StCook);
    beep_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      time_q     <= 16'h0000;
      beep_cnt_q <= 4'd0;
      heat_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      beep_cnt_q <= beep_cnt_d;
      heat_q     <= heat_d;
      beep_q     <= beep_d;
    end
  end

  assign min_tens  = time_q[15:12];
  assign min_ones  = time_q[11:8];
  assign sec_tens  = time_q[7:4];
  assign sec_ones  = time_q[3:0];
  assign heat_on   = heat_q;
  assign done_beep = beep_q;
  assign state     = state_q;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed self-checking bench for microwave_cook_ctrl.
module tb_microwave_cook_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       btn_add_min;
  logic       btn_add_10s;
  logic       btn_start;
  logic       btn_stop;
  logic       door_open;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       heat_on;
  logic       done_beep;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_COOK = 3'd2, S_PAUSE = 3'd3,
                         S_DONE = 3'd4;

  // Event bits for step(): {rst, tick, add_min, add_10s, start, stop}
  localparam logic [5:0] E_NONE = 6'b000000, E_RST = 6'b100000, E_TICK = 6'b010000,
                         E_MIN = 6'b001000, E_10S = 6'b000100, E_START = 6'b000010,
                         E_STOP = 6'b000001;

  microwave_cook_ctrl #(.BEEP_SECS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .btn_add_min(btn_add_min),
    .btn_add_10s(btn_add_10s),
    .btn_start  (btn_start),
    .btn_stop   (btn_stop),
    .door_open  (door_open),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .heat_on    (heat_on),
    .done_beep  (done_beep),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] tm = {min_tens, min_ones, sec_tens, sec_ones};

  // Present one cycle of events, let the edge sample them, sample #1 later.
  task automatic step(input logic [5:0] ev);
    {rst, tick_1hz, btn_add_min, btn_add_10s, btn_start, btn_stop} = ev;
    @(posedge clk);
    #1;
    {rst, tick_1hz, btn_add_min, btn_add_10s, btn_start, btn_stop} = E_NONE;
  endtask

  task automatic test_reset();
    step(E_RST);
    total++;
    if ({state, tm, heat_on, done_beep} !== {S_IDLE, 16'h0000, 1'b0, 1'b0}) begin
      $display("FAIL reset: got st=%0d t=%h h=%b b=%b want st=0 t=0000 h=0 b=0",
               state, tm, heat_on, done_beep);
      bad++;
    end
  endtask

  task automatic test_basic_cook();
    step(E_10S);
    step(E_10S);
    total++;
    if ({state, tm} !== {S_SET, 16'h0020}) begin
      $display("FAIL set_0020: got st=%0d t=%h want st=1 t=0020", state, tm); bad++;
    end
    step(E_START);
    total++;
    if ({state, heat_on} !== {S_COOK, 1'b1}) begin
      $display("FAIL cook_start: got st=%0d h=%b want st=2 h=1", state, heat_on); bad++;
    end
    step(E_TICK);
    total++;
    if (tm !== 16'h0019) begin
      $display("FAIL first_tick: got t=%h want 0019", tm); bad++;
    end
    for (int i = 0; i < 18; i++) step(E_TICK);
    total++;
    if ({state, tm, heat_on} !== {S_COOK, 16'h0001, 1'b1}) begin
      $display("FAIL tick_19: got st=%0d t=%h h=%b want st=2 t=0001 h=1", state, tm, heat_on);
      bad++;
    end
    step(E_TICK);
    total++;
    if ({state, tm, heat_on, done_beep} !== {S_DONE, 16'h0000, 1'b0, 1'b1}) begin
      $display("FAIL done_entry: got st=%0d t=%h h=%b b=%b want st=4 t=0000 h=0 b=1",
               state, tm, heat_on, done_beep);
      bad++;
    end
    step(E_TICK);
    step(E_TICK);
    total++;
    if ({state, done_beep} !== {S_DONE, 1'b1}) begin
      $display("FAIL beep_2ticks: got st=%0d b=%b want st=4 b=1", state, done_beep); bad++;
    end
    step(E_TICK);
    total++;
    if ({state, done_beep} !== {S_IDLE, 1'b0}) begin
      $display("FAIL beep_end: got st=%0d b=%b want st=0 b=0", state, done_beep); bad++;
    end
  endtask

  task automatic test_entry();
    for (int i = 0; i < 7; i++) step(E_10S);
    total++;
    if ({state, tm} !== {S_SET, 16'h0110}) begin
      $display("FAIL add_10s_x7: got st=%0d t=%h want st=1 t=0110", state, tm); bad++;
    end
    for (int i = 0; i < 99; i++) step(E_MIN);
    total++;
    if (tm !== 16'h9959) begin
      $display("FAIL add_min_sat: got t=%h want 9959", tm); bad++;
    end
    step(E_MIN);
    step(E_10S);
    total++;
    if (tm !== 16'h9959) begin
      $display("FAIL sat_hold: got t=%h want 9959", tm); bad++;
    end
    step(E_STOP);
    total++;
    if ({state, tm} !== {S_IDLE, 16'h0000}) begin
      $display("FAIL set_clear: got st=%0d t=%h want st=0 t=0000", state, tm); bad++;
    end
  endtask

  task automatic test_borrow();
    for (int i = 0; i < 10; i++) step(E_MIN);
    step(E_START);
    step(E_TICK);
    total++;
    if (tm !== 16'h0959) begin
      $display("FAIL borrow_1000: got t=%h want 0959", tm); bad++;
    end
    step(E_STOP);
    step(E_STOP);
    step(E_MIN);
    step(E_START);
    step(E_TICK);
    total++;
    if (tm !== 16'h0059) begin
      $display("FAIL borrow_0100: got t=%h want 0059", tm); bad++;
    end
    step(E_STOP);
    step(E_STOP);
    total++;
    if ({state, tm} !== {S_IDLE, 16'h0000}) begin
      $display("FAIL borrow_clear: got st=%0d t=%h want st=0 t=0000", state, tm); bad++;
    end
  endtask

  task automatic test_door();
    for (int i = 0; i < 3; i++) step(E_10S);
    step(E_START);
    door_open = 1'b1;
    step(E_NONE);
    total++;
    if ({state, heat_on, tm} !== {S_PAUSE, 1'b0, 16'h0030}) begin
      $display("FAIL door_pause: got st=%0d h=%b t=%h want st=3 h=0 t=0030", state, heat_on, tm);
      bad++;
    end
    step(E_START);
    step(E_TICK);
    total++;
    if ({state, heat_on, tm} !== {S_PAUSE, 1'b0, 16'h0030}) begin
      $display("FAIL door_start: got st=%0d h=%b t=%h want st=3 h=0 t=0030", state, heat_on, tm);
      bad++;
    end
    door_open = 1'b0;
    step(E_NONE);
    step(E_START);
    total++;
    if ({state, heat_on} !== {S_COOK, 1'b1}) begin
      $display("FAIL door_resume: got st=%0d h=%b want st=2 h=1", state, heat_on); bad++;
    end
    step(E_STOP);
    step(E_STOP);
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) step(E_10S);
    step(E_START | E_TICK);
    total++;
    if ({state, tm} !== {S_COOK, 16'h0030}) begin
      $display("FAIL start_tick: got st=%0d t=%h want st=2 t=0030", state, tm); bad++;
    end
    step(E_MIN | E_TICK);
    total++;
    if ({state, tm} !== {S_COOK, 16'h0130}) begin
      $display("FAIL add_tick: got st=%0d t=%h want st=2 t=0130", state, tm); bad++;
    end
    step(E_10S);
    total++;
    if (tm !== 16'h0130) begin
      $display("FAIL cook_10s_ignored: got t=%h want 0130", tm); bad++;
    end
    step(E_STOP | E_START | E_TICK);
    total++;
    if ({state, tm, heat_on} !== {S_PAUSE, 16'h0130, 1'b0}) begin
      $display("FAIL stop_start_tick: got st=%0d t=%h h=%b want st=3 t=0130 h=0",
               state, tm, heat_on);
      bad++;
    end
    step(E_STOP);
    total++;
    if ({state, tm} !== {S_IDLE, 16'h0000}) begin
      $display("FAIL pause_clear: got st=%0d t=%h want st=0 t=0000", state, tm); bad++;
    end
  endtask

  task automatic test_reset_mid_cook();
    for (int i = 0; i < 5; i++) step(E_MIN);
    step(E_START);
    total++;
    if ({state, tm, heat_on} !== {S_COOK, 16'h0500, 1'b1}) begin
      $display("FAIL cook_0500: got st=%0d t=%h h=%b want st=2 t=0500 h=1", state, tm, heat_on);
      bad++;
    end
    step(E_RST);
    total++;
    if ({state, tm, heat_on} !== {S_IDLE, 16'h0000, 1'b0}) begin
      $display("FAIL reset_mid: got st=%0d t=%h h=%b want st=0 t=0000 h=0", state, tm, heat_on);
      bad++;
    end
    step(E_START);
    step(E_TICK);
    total++;
    if ({state, tm, heat_on} !== {S_IDLE, 16'h0000, 1'b0}) begin
      $display("FAIL idle_start: got st=%0d t=%h h=%b want st=0 t=0000 h=0", state, tm, heat_on);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    // Short cook to DONE, then a button exits DONE immediately.
    step(E_10S);
    step(E_START);
    for (int i = 0; i < 10; i++) step(E_TICK);
    total++;
    if ({state, done_beep} !== {S_DONE, 1'b1}) begin
      $display("FAIL b2b_done: got st=%0d b=%b want st=4 b=1", state, done_beep); bad++;
    end
    step(E_MIN);
    total++;
    if ({state, done_beep, tm} !== {S_IDLE, 1'b0, 16'h0000}) begin
      $display("FAIL done_btn_exit: got st=%0d b=%b t=%h want st=0 b=0 t=0000",
               state, done_beep, tm);
      bad++;
    end
    step(E_MIN);
    step(E_10S);
    step(E_10S);
    total++;
    if ({state, tm} !== {S_SET, 16'h0120}) begin
      $display("FAIL b2b_adds: got st=%0d t=%h want st=1 t=0120", state, tm); bad++;
    end
  endtask

  initial begin
    {rst, tick_1hz, btn_add_min, btn_add_10s, btn_start, btn_stop} = E_RST;
    door_open = 1'b0;
    test_reset();
    test_basic_cook();
    test_entry();
    test_borrow();
    test_door();
    test_priority();
    test_reset_mid_cook();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
